// File: rtl/arb_pkg.sv
// Shared types and sizing for the four-way round-robin arbiter.
package arb_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned ID_W    = 2;

   typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t;

   function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
      id_to_onehot     = '0;
      id_to_onehot[id] = 1'b1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ptr+3, ptr (mod 4)
// and reports the first requesting index.
module rr_pick
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic               any,
   output logic [ID_W-1:0]    win_id
);

   logic [ID_W-1:0] idx;

   // Offset NUM_REQ truncates to 0, so the last owner is searched last.
   always_comb begin
      any    = 1'b0;
      win_id = '0;
      idx    = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         idx = ptr + ID_W'(i);
         if (!any && req[idx]) begin
            any    = 1'b1;
            win_id = idx;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant, optional
// hold limit and a mandatory one-cycle idle gap between grants.
module rr_arbiter4
   import arb_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 8
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid,
   output logic [ID_W-1:0]    grant_id,
   output logic               timeout
);

   arb_state_t      state;
   logic [ID_W-1:0] ptr;
   logic [7:0]      hold_cnt;
   logic            any;
   logic [ID_W-1:0] win_id;
   logic            owner_req;
   logic            limit_hit;

   rr_pick u_pick (
      .req    (req),
      .ptr    (ptr),
      .any    (any),
      .win_id (win_id)
   );

   assign owner_req = req[grant_id];
   assign limit_hit = (HOLD_MAX != 0) && (hold_cnt == 8'(HOLD_MAX));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         ptr         <= '1;
         hold_cnt    <= '0;
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_id    <= '0;
         timeout     <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any) begin
                  grant       <= id_to_onehot(win_id);
                  grant_valid <= 1'b1;
                  grant_id    <= win_id;
                  hold_cnt    <= 8'd1;
                  state       <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // Release and timeout share the exit path; timeout only flags
               // the case where the owner still wanted the resource.
               if (!owner_req || limit_hit) begin
                  grant       <= '0;
                  grant_valid <= 1'b0;
                  ptr         <= grant_id;
                  timeout     <= owner_req;
                  state       <= ST_IDLE;
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: vector table plus timeout, async-reset and
// unlimited-hold sequences.
module tb_rr_arbiter4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] req0 = 4'b0000;

   logic [3:0] grant, grant0;
   logic       grant_valid, grant_valid0;
   logic [1:0] grant_id, grant_id0;
   logic       timeout, timeout0;

   int errors = 0;
   int checks = 0;

   rr_arbiter4 #(.HOLD_MAX(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .timeout     (timeout)
   );

   rr_arbiter4 #(.HOLD_MAX(0)) dut0 (
      .clk         (clk),
      .reset       (reset),
      .req         (req0),
      .grant       (grant0),
      .grant_valid (grant_valid0),
      .grant_id    (grant_id0),
      .timeout     (timeout0)
   );

   always #5 clk = ~clk;

   logic [7:0] obs, obs0;
   assign obs  = {grant, grant_valid, grant_id, timeout};
   assign obs0 = {grant0, grant_valid0, grant_id0, timeout0};

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] g;
      logic       v;
      logic [1:0] id;
      logic       t;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rst, input logic [3:0] r,
                               input logic [3:0] g, input logic [1:0] id);
      vec_t e;
      e.rst = rst;
      e.req = r;
      e.g   = g;
      e.v   = |g;
      e.id  = id;
      e.t   = 1'b0;
      return e;
   endfunction

   function automatic logic [7:0] pk(input logic [3:0] g, input logic v,
                                     input logic [1:0] id, input logic t);
      return {g, v, id, t};
   endfunction

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got grant=%b valid=%b id=%0d timeout=%b, want grant=%b valid=%b id=%0d timeout=%b",
                  nm, act[7:4], act[3], act[2:1], act[0], exp[7:4], exp[3], exp[2:1], exp[0]);
      end
   endtask

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, checked before any clock edge
      #1 reset = 1'b1;
      #1 check("reset_state", obs, pk(4'b0000, 1'b0, 2'd0, 1'b0));

      // Single request
      tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd0));
      tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 2'd0));
      tbl.push_back(mk(1'b0, 4'b0100, 4'b0100, 2'd2));
      tbl.push_back(mk(1'b0, 4'b0100, 4'b0100, 2'd2));
      tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 2'd2));
      tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 2'd2));
      // Fairness from reset: order 0,1,2,3,0 with one idle cycle between grants
      tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd0));
      tbl.push_back(mk(1'b0, 4'b1111, 4'b0001, 2'd0));
      tbl.push_back(mk(1'b0, 4'b1111, 4'b0001, 2'd0));
      tbl.push_back(mk(1'b0, 4'b1110, 4'b0000, 2'd0));
      tbl.push_back(mk(1'b0, 4'b1111, 4'b0010, 2'd1));
      tbl.push_back(mk(1'b0, 4'b1111, 4'b0010, 2'd1));
      tbl.push_back(mk(1'b0, 4'b1101, 4'b0000, 2'd1));
      tbl.push_back(mk(1'b0, 4'b1111, 4'b0100, 2'd2));
      tbl.push_back(mk(1'b0, 4'b1111, 4'b0100, 2'd2));
      tbl.push_back(mk(1'b0, 4'b1011, 4'b0000, 2'd2));
      tbl.push_back(mk(1'b0, 4'b1111, 4'b1000, 2'd3));
      tbl.push_back(mk(1'b0, 4'b1111, 4'b1000, 2'd3));
      tbl.push_back(mk(1'b0, 4'b0111, 4'b0000, 2'd3));
      tbl.push_back(mk(1'b0, 4'b1111, 4'b0001, 2'd0));
      tbl.push_back(mk(1'b0, 4'b1111, 4'b0001, 2'd0));
      tbl.push_back(mk(1'b0, 4'b1110, 4'b0000, 2'd0));
      // Wrap-around: last owner 3, then 1001 goes to 0
      tbl.push_back(mk(1'b0, 4'b1000, 4'b1000, 2'd3));
      tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 2'd3));
      tbl.push_back(mk(1'b0, 4'b1001, 4'b0001, 2'd0));
      // Non-owner changes while busy are ignored
      tbl.push_back(mk(1'b0, 4'b0111, 4'b0001, 2'd0));
      tbl.push_back(mk(1'b0, 4'b0110, 4'b0000, 2'd0));
      tbl.push_back(mk(1'b0, 4'b0110, 4'b0010, 2'd1));
      tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 2'd1));

      foreach (tbl[i]) begin
         reset = tbl[i].rst;
         req   = tbl[i].req;
         edge_sample();
         check($sformatf("vec%0d", i), obs, pk(tbl[i].g, tbl[i].v, tbl[i].id, tbl[i].t));
      end

      // Timeout with HOLD_MAX=8 and both 0 and 1 requesting forever
      reset = 1'b1;
      #2 reset = 1'b0;
      req = 4'b0011;
      for (int c = 1; c <= 8; c++) begin
         edge_sample();
         check($sformatf("to_hold0_c%0d", c), obs, pk(4'b0001, 1'b1, 2'd0, 1'b0));
      end
      edge_sample();
      check("to_pulse0", obs, pk(4'b0000, 1'b0, 2'd0, 1'b1));
      for (int c = 1; c <= 8; c++) begin
         edge_sample();
         check($sformatf("to_hold1_c%0d", c), obs, pk(4'b0010, 1'b1, 2'd1, 1'b0));
      end
      edge_sample();
      check("to_pulse1", obs, pk(4'b0000, 1'b0, 2'd1, 1'b1));
      edge_sample();
      check("to_next0", obs, pk(4'b0001, 1'b1, 2'd0, 1'b0));
      req = 4'b0000;
      edge_sample();
      check("to_release", obs, pk(4'b0000, 1'b0, 2'd0, 1'b0));

      // Async reset between edges while requester 1 owns the grant
      req = 4'b0010;
      edge_sample();
      check("ar_granted", obs, pk(4'b0010, 1'b1, 2'd1, 1'b0));
      #3 reset = 1'b1;
      #1 check("ar_cleared", obs, pk(4'b0000, 1'b0, 2'd0, 1'b0));
      #1 reset = 1'b0;
      edge_sample();
      check("ar_regrant", obs, pk(4'b0010, 1'b1, 2'd1, 1'b0));
      req = 4'b0000;
      edge_sample();
      check("ar_release", obs, pk(4'b0000, 1'b0, 2'd1, 1'b0));

      // HOLD_MAX=0: grant never revoked, including past hold counter saturation
      reset = 1'b1;
      #2 reset = 1'b0;
      req0 = 4'b0001;
      for (int c = 1; c <= 300; c++) begin
         edge_sample();
         check($sformatf("nolimit_c%0d", c), obs0, pk(4'b0001, 1'b1, 2'd0, 1'b0));
      end
      req0 = 4'b0000;
      edge_sample();
      check("nolimit_release", obs0, pk(4'b0000, 1'b0, 2'd0, 1'b0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares one resource, such as a single counter or datapath, between requesters. It issues a one-hot registered grant, holds it until the owner releases or a hold limit expires, then rotates priority so no requester starves. A 2-bit pointer records the last owner and wraps modulo 4.

## Interface
- HOLD_MAX, default 8: maximum consecutive cycles one grant may be held. 0 disables the limit. Legal range 0..255.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  4  per-requester request, level-sensitive; the owner holds it high while using the resource
- grant  output  4  one-hot grant, registered; all-zero when nothing is granted
- grant_valid  output  1  OR of grant, registered
- grant_id  output  2  index of the current owner; holds the last owner when grant_valid=0
- timeout  output  1  one-cycle pulse: the grant was revoked by HOLD_MAX

## Operation
- State: ST_IDLE, ST_BUSY. ptr[1:0] = last granted index. hold_cnt counts the cycles of the current grant.
- Search order: ptr+1, ptr+2, ptr+3, ptr, all modulo 4 with wrap 3→0. The first index with req high wins.
- ST_IDLE:
  - If req≠0 at a clock edge: grant[winner]=1, grant_id=winner, grant_valid=1, hold_cnt=1, go to ST_BUSY.
  - If req=0: stay in ST_IDLE; outputs stay 0, except grant_id holds its value.
- ST_BUSY, owner k:
  - Release: if req[k]=0 at an edge, clear grant, set ptr=k, go to ST_IDLE.
  - Timeout: if req[k]=1, HOLD_MAX≠0 and hold_cnt==HOLD_MAX at an edge, clear grant, set ptr=k, assert timeout for exactly that cycle, go to ST_IDLE. Because ptr=k, requester k is searched last on the next arbitration.
  - Otherwise: keep the grant and increment hold_cnt, saturating so it never wraps.
- Every grant is followed by exactly one idle cycle (grant=0) before the next grant. This gives the shared resource a guaranteed handover gap.
- Changes to req of non-owners during ST_BUSY are ignored until the next ST_IDLE edge.
- Reset values: state=ST_IDLE, ptr=3 (so the first search starts at index 0), hold_cnt=0, grant=0, grant_valid=0, grant_id=0, timeout=0.
- Reset asserted mid-grant clears all outputs immediately, without waiting for a clock edge. After reset deasserts, arbitration restarts from index 0.

## Timing
- Request to grant: 1 edge. req is sampled at edge k in ST_IDLE; grant is visible after edge k.
- Release to grant drop: 1 edge.
- Release to next grant: 2 edges, because of the mandatory idle cycle.
- Maximum grant width: HOLD_MAX cycles, or unbounded when HOLD_MAX=0.
- Worst-case wait for a continuously requesting input: 3×(HOLD_MAX+1) cycles after its first sampled request.
- All outputs come directly from flops. There is no combinational path from req to the outputs.

## Structure
- Package arb_pkg holds:
  - NUM_REQ=4 and ID_W=2
  - typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t
- Sub-module rr_pick: purely combinational, inputs req[3:0] and ptr[1:0], outputs any and win_id[1:0]. It is instantiated once.
- The top level contains the FSM, ptr, hold_cnt and the output registers.

## Test plan
- Reset then single request: reset, then req=4'b0100 → grant=4'b0100 and grant_id=2 one edge later. Drop req → grant=0 one edge later.
- Fairness: req=4'b1111 held, with each owner dropping its own req for one cycle after 2 cycles of grant → grant order 0,1,2,3,0. Each grant is separated by exactly one all-zero cycle.
- Timeout: HOLD_MAX=8, req=4'b0011 held permanently → grant[0] high for exactly 8 cycles, timeout pulses once, then one idle cycle, then grant[1] for 8 cycles.
- Wrap-around: make the last owner 3, then req=4'b1001 → the next grant goes to 0, not 3.
- Async reset mid-grant: assert reset between clock edges while grant=4'b0010 → all outputs 0 before the next edge. After release with req=4'b0010, grant=4'b0010 on the first edge.
- HOLD_MAX=0: single requester held for 300 cycles → grant stays high throughout and timeout is never asserted.
